// File: rtl/router_pkg.sv
// Shared definitions for the router network-interface transmitter:
// default widths, flit type codes, header field offsets and FSM states.
package router_pkg;

  localparam int COORD_W_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int FLIT_W_DEF  = 32;
  localparam int CREDITS_DEF = 4;

  // Two-bit type code sitting just above the length field of a header.
  localparam logic [1:0] FLIT_TYPE_HEAD = 2'b10;
  localparam logic [1:0] FLIT_TYPE_BODY = 2'b00;

  // Header layout, LSB first: dst_x, dst_y, len, type, zero pad.
  function automatic int hdr_x_lsb();
    return 0;
  endfunction

  function automatic int hdr_y_lsb(input int coord_w);
    return coord_w;
  endfunction

  function automatic int hdr_len_lsb(input int coord_w);
    return 2 * coord_w;
  endfunction

  function automatic int hdr_type_lsb(input int coord_w, input int len_w);
    return 2 * coord_w + len_w;
  endfunction

  // Encoding is fixed so the debug port value is stable across builds.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

endpackage

// File: rtl/router_credit_ctr.sv
// Credit counter toward the router input buffer. A send consumes one
// credit, a credit_ret pulse gives one back; both together cancel out.
// A return that would overflow the counter is dropped and flagged in a
// sticky error bit that only reset clears.
module router_credit_ctr #(
  parameter  int CREDITS = 4,
  localparam int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_i,
  input  logic             credit_ret_i,
  output logic [CNT_W-1:0] count_o,
  output logic             can_send_o,
  output logic             credit_err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Next credit count and error flag from this cycle's send/return pair.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    case ({send_i, credit_ret_i})
      2'b10: count_d = count_q - CNT_W'(1);
      2'b01: begin
        if (count_q == MAX_CNT) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Counter and sticky error registers; reset refills all credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= MAX_CNT;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o      = count_q;
  assign can_send_o   = (count_q != '0);
  assign credit_err_o = err_q;

endmodule

// File: rtl/router_flit_tx.sv
// Network-interface transmitter: takes a packet request plus a payload
// word stream and emits a head flit followed by len body flits into the
// XY router, gated by credits. Flit outputs are registered, so a send
// decided in one cycle is visible on flit_* for exactly the next cycle.
//
// Handshakes: a request transfers on a cycle with req_valid && req_ready;
// a payload word transfers on a cycle with pl_valid && pl_ready. The
// transmitter never asserts a ready that depends on its own valid being
// withdrawn, and pl_ready is only ever high together with pl_valid.
module router_flit_tx
  import router_pkg::*;
#(
  parameter  int COORD_W = COORD_W_DEF,
  parameter  int LEN_W   = LEN_W_DEF,
  parameter  int FLIT_W  = FLIT_W_DEF,
  parameter  int CREDITS = CREDITS_DEF,
  localparam int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_dst_x,
  input  logic [COORD_W-1:0] req_dst_y,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               pl_valid,
  output logic               pl_ready,
  input  logic [FLIT_W-1:0]  pl_data,
  output logic               flit_valid,
  output logic [FLIT_W-1:0]  flit_data,
  output logic               flit_head,
  output logic               flit_tail,
  input  logic               credit_ret,
  output logic               credit_err,
  output logic [1:0]         dbg_state_o,
  output logic [CNT_W-1:0]   dbg_credits_o
);

  localparam int X_LSB    = hdr_x_lsb();
  localparam int Y_LSB    = hdr_y_lsb(COORD_W);
  localparam int LEN_LSB  = hdr_len_lsb(COORD_W);
  localparam int TYPE_LSB = hdr_type_lsb(COORD_W, LEN_W);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] dst_x_q, dst_x_d;
  logic [COORD_W-1:0] dst_y_q, dst_y_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   body_cnt_q, body_cnt_d;

  logic               flit_valid_q, flit_valid_d;
  logic [FLIT_W-1:0]  flit_data_q, flit_data_d;
  logic               flit_head_q, flit_head_d;
  logic               flit_tail_q, flit_tail_d;

  logic               send;
  logic               can_send;
  logic [CNT_W-1:0]   credit_cnt;
  logic [FLIT_W-1:0]  header;

  router_credit_ctr #(
    .CREDITS (CREDITS)
  ) u_credit_ctr (
    .clk          (clk),
    .rst          (rst),
    .send_i       (send),
    .credit_ret_i (credit_ret),
    .count_o      (credit_cnt),
    .can_send_o   (can_send),
    .credit_err_o (credit_err)
  );

  // Routing header assembled from the captured request fields.
  always_comb begin
    header = '0;
    header[X_LSB +: COORD_W]  = dst_x_q;
    header[Y_LSB +: COORD_W]  = dst_y_q;
    header[LEN_LSB +: LEN_W]  = len_q;
    header[TYPE_LSB +: 2]     = FLIT_TYPE_HEAD;
  end

  // Next state, handshake readies and the flit to register this cycle.
  always_comb begin
    state_d      = state_q;
    dst_x_d      = dst_x_q;
    dst_y_d      = dst_y_q;
    len_d        = len_q;
    body_cnt_d   = body_cnt_q;
    req_ready    = 1'b0;
    pl_ready     = 1'b0;
    send         = 1'b0;
    flit_valid_d = 1'b0;
    flit_data_d  = '0;
    flit_head_d  = 1'b0;
    flit_tail_d  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          dst_x_d = req_dst_x;
          dst_y_d = req_dst_y;
          len_d   = req_len;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (can_send) begin
          send         = 1'b1;
          flit_valid_d = 1'b1;
          flit_data_d  = header;
          flit_head_d  = 1'b1;
          if (len_q == '0) begin
            flit_tail_d = 1'b1;
            state_d     = IDLE;
          end else begin
            body_cnt_d = len_q;
            state_d    = BODY;
          end
        end
      end
      BODY: begin
        if (can_send && pl_valid) begin
          send         = 1'b1;
          pl_ready     = 1'b1;
          flit_valid_d = 1'b1;
          flit_data_d  = pl_data;
          body_cnt_d   = body_cnt_q - LEN_W'(1);
          if (body_cnt_q == LEN_W'(1)) begin
            flit_tail_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and registered flit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dst_x_q      <= '0;
      dst_y_q      <= '0;
      len_q        <= '0;
      body_cnt_q   <= '0;
      flit_valid_q <= 1'b0;
      flit_data_q  <= '0;
      flit_head_q  <= 1'b0;
      flit_tail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dst_x_q      <= dst_x_d;
      dst_y_q      <= dst_y_d;
      len_q        <= len_d;
      body_cnt_q   <= body_cnt_d;
      flit_valid_q <= flit_valid_d;
      flit_data_q  <= flit_data_d;
      flit_head_q  <= flit_head_d;
      flit_tail_q  <= flit_tail_d;
    end
  end

  assign flit_valid    = flit_valid_q;
  assign flit_data     = flit_data_q;
  assign flit_head     = flit_head_q;
  assign flit_tail     = flit_tail_q;
  assign dbg_state_o   = state_q;
  assign dbg_credits_o = credit_cnt;

endmodule

// File: tb/tb_router_flit_tx.sv
// Bench for router_flit_tx: hand-written sequences for reset, credit
// stalls, credit counter corner cases, mid-packet reset and back-to-back
// packets, then a table of packets with random payload and credit timing.
`timescale 1ns/1ps
module tb_router_flit_tx;
  import router_pkg::*;

  localparam int FLIT_W = 32;
  localparam int CNT_W  = 3;
  localparam int W      = FLIT_W + 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [7:0]        req_dst_x = '0;
  logic [7:0]        req_dst_y = '0;
  logic [3:0]        req_len = '0;
  logic              pl_valid = 1'b0;
  logic              pl_ready;
  logic [FLIT_W-1:0] pl_data = '0;
  logic              flit_valid;
  logic [FLIT_W-1:0] flit_data;
  logic              flit_head;
  logic              flit_tail;
  wire               credit_ret;
  logic              credit_err;
  logic [1:0]        dbg_state;
  logic [CNT_W-1:0]  dbg_credits;

  logic auto_credit = 1'b0;
  logic auto_ret    = 1'b0;
  logic man_ret     = 1'b0;
  assign credit_ret = auto_credit ? auto_ret : man_ret;

  always #5 clk = ~clk;

  router_flit_tx dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dst_x     (req_dst_x),
    .req_dst_y     (req_dst_y),
    .req_len       (req_len),
    .pl_valid      (pl_valid),
    .pl_ready      (pl_ready),
    .pl_data       (pl_data),
    .flit_valid    (flit_valid),
    .flit_data     (flit_data),
    .flit_head     (flit_head),
    .flit_tail     (flit_tail),
    .credit_ret    (credit_ret),
    .credit_err    (credit_err),
    .dbg_state_o   (dbg_state),
    .dbg_credits_o (dbg_credits)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]      exp_q[$];   // {head, tail, data}
  logic [FLIT_W-1:0] pl_q[$];
  int                flit_cyc[$];
  int                rr_cyc[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int flit_cnt = 0;
  int pl_ready_cnt = 0;
  int ret_pending = 0;
  logic pl_gaps = 1'b0;
  logic rr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Output monitor: compares every flit against the expected queue.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (pl_ready) pl_ready_cnt++;
    checks++;
    if (pl_ready && !pl_valid) begin
      failures++;
      $display("FAIL pl_ready_gate: actual pl_ready=1 with pl_valid=0, required pl_ready=0");
    end
    if (flit_valid) begin
      flit_cnt++;
      flit_cyc.push_back(cyc);
      if (auto_credit) ret_pending++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_flit: actual data=%08h head=%0b tail=%0b, required no flit",
                 flit_data, flit_head, flit_tail);
      end else begin
        e = exp_q.pop_front();
        if ({flit_head, flit_tail, flit_data} !== e) begin
          failures++;
          $display("FAIL flit_%0d: actual head=%0b tail=%0b data=%08h required head=%0b tail=%0b data=%08h",
                   flit_cnt, flit_head, flit_tail, flit_data, e[W-1], e[W-2], e[FLIT_W-1:0]);
        end
      end
    end
    if (req_ready && !rr_prev) rr_cyc.push_back(cyc);
    rr_prev = req_ready;
  end

  // Payload source: presents queued words, optionally with random gaps.
  initial begin : pl_driver
    forever begin
      @(posedge clk); #1;
      if (pl_q.size() != 0 && (!pl_gaps || $urandom_range(0, 3) != 0)) begin
        pl_valid = 1'b1;
        pl_data  = pl_q[0];
      end else begin
        pl_valid = 1'b0;
        pl_data  = $urandom;
      end
      @(negedge clk);
      if (pl_valid && pl_ready && pl_q.size() != 0) void'(pl_q.pop_front());
    end
  end

  // Router model: returns one credit per received flit at random delays.
  initial begin : credit_driver
    forever begin
      @(posedge clk); #1;
      if (auto_credit && ret_pending > 0 && $urandom_range(0, 1) == 1) begin
        auto_ret = 1'b1;
        ret_pending--;
      end else begin
        auto_ret = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; man_ret = 1'b0; auto_credit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.delete(); pl_q.delete(); ret_pending = 0;
    rst = 1'b0;
  endtask

  task automatic push_pkt(input logic [31:0] hdr, input logic [3:0] len);
    logic [FLIT_W-1:0] w;
    exp_q.push_back({1'b1, (len == 4'd0), hdr});
    for (int i = 0; i < int'(len); i++) begin
      w = $urandom;
      pl_q.push_back(w);
      exp_q.push_back({1'b0, (i == int'(len) - 1), w});
    end
  endtask

  task automatic issue_req(input logic [7:0] x, input logic [7:0] y, input logic [3:0] len);
    int t;
    t = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_dst_x = x; req_dst_y = y; req_len = len;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) timeout_fail("req_accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_dst_x = 8'($urandom); req_dst_y = 8'($urandom); req_len = 4'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || pl_q.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      timeout_fail(name);
      exp_q.delete(); pl_q.delete();
    end
    t = 0;
    while (auto_credit && ret_pending != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout_fail({name, "_credits"});
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_ret();
    @(posedge clk); #1; man_ret = 1'b1;
    @(posedge clk); #1; man_ret = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  len;
    logic        gaps;
    logic [31:0] exp_hdr;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main test ----------------
  initial begin : main
    int base;
    int n0;
    int r0;
    int t;

    vecs[0] = '{x: 8'h03, y: 8'h05, len: 4'd0,  gaps: 1'b0, exp_hdr: 32'h00200503};
    vecs[1] = '{x: 8'h00, y: 8'h00, len: 4'd1,  gaps: 1'b0, exp_hdr: 32'h00210000};
    vecs[2] = '{x: 8'hFF, y: 8'hFF, len: 4'd15, gaps: 1'b0, exp_hdr: 32'h002FFFFF};
    vecs[3] = '{x: 8'h12, y: 8'h34, len: 4'd7,  gaps: 1'b1, exp_hdr: 32'h00273412};
    vecs[4] = '{x: 8'hA5, y: 8'h5A, len: 4'd2,  gaps: 1'b1, exp_hdr: 32'h00225AA5};
    vecs[5] = '{x: 8'h01, y: 8'h80, len: 4'd15, gaps: 1'b1, exp_hdr: 32'h002F8001};

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_flit_data", 64'(flit_data), 64'd0);
    chk("rst_flit_head_tail", 64'({flit_head, flit_tail}), 64'd0);
    chk("rst_credit_err", 64'(credit_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_credits", 64'(dbg_credits), 64'd4);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));

    // Zero-length packet: single head+tail flit, one credit used
    push_pkt(32'h00200503, 4'd0);
    issue_req(8'h03, 8'h05, 4'd0);
    wait_drain("len0");
    chk("len0_credits", 64'(dbg_credits), 64'd3);

    // len=3 with payload waiting from the start: exactly 3 consumes
    do_reset();
    base = pl_ready_cnt;
    n0 = flit_cyc.size();
    push_pkt(32'h00230201, 4'd3);
    issue_req(8'h01, 8'h02, 4'd3);
    wait_drain("len3");
    chk("len3_pl_ready_cycles", 64'(pl_ready_cnt - base), 64'd3);
    chk("len3_credits", 64'(dbg_credits), 64'd0);
    if (flit_cyc.size() >= n0 + 4)
      chk("len3_consecutive", 64'(flit_cyc[n0 + 3] - flit_cyc[n0]), 64'd3);
    else
      timeout_fail("len3_flit_count");

    // Credit stall: len=4 with 4 credits stalls before the last body flit
    do_reset();
    base = flit_cnt;
    push_pkt(32'h00240907, 4'd4);
    issue_req(8'h07, 8'h09, 4'd4);
    repeat (6) @(negedge clk);
    chk("stall_flits", 64'(flit_cnt - base), 64'd4);
    chk("stall_credits", 64'(dbg_credits), 64'd0);
    chk("stall_state", 64'(dbg_state), 64'(BODY));
    chk("stall_pl_ready", 64'(pl_ready), 64'd0);
    pulse_ret();
    repeat (4) @(negedge clk);
    chk("stall_resume_flits", 64'(flit_cnt - base), 64'd5);
    chk("stall_resume_queue", 64'(exp_q.size()), 64'd0);
    chk("stall_resume_state", 64'(dbg_state), 64'(IDLE));

    // Simultaneous send and return at count 2, then overflow return
    do_reset();
    push_pkt(32'h00210404, 4'd1);
    issue_req(8'h04, 8'h04, 4'd1);
    wait_drain("pre_coincide");
    chk("pre_coincide_credits", 64'(dbg_credits), 64'd2);
    chk("pre_coincide_req_ready", 64'(req_ready), 64'd1);
    push_pkt(32'h00200606, 4'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_dst_x = 8'h06; req_dst_y = 8'h06; req_len = 4'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    man_ret = 1'b1;
    chk("coincide_state", 64'(dbg_state), 64'(HEAD));
    @(posedge clk); #1;
    man_ret = 1'b0;
    chk("coincide_credits", 64'(dbg_credits), 64'd2);
    wait_drain("coincide");
    pulse_ret();
    pulse_ret();
    chk("refill_credits", 64'(dbg_credits), 64'd4);
    chk("refill_err", 64'(credit_err), 64'd0);
    pulse_ret();
    chk("overflow_err", 64'(credit_err), 64'd1);
    chk("overflow_credits", 64'(dbg_credits), 64'd4);

    // Reset mid-BODY after two of four body flits (error flag still set)
    base = pl_ready_cnt;
    push_pkt(32'h00240302, 4'd4);
    issue_req(8'h02, 8'h03, 4'd4);
    t = 0;
    while (pl_ready_cnt - base < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) timeout_fail("mid_body_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_flit_valid", 64'(flit_valid), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'(IDLE));
    chk("midrst_credits", 64'(dbg_credits), 64'd4);
    chk("midrst_err", 64'(credit_err), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete(); pl_q.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back len=1 packets at minimum period
    do_reset();
    auto_credit = 1'b1;
    n0 = flit_cyc.size();
    push_pkt(32'h00210101, 4'd1);
    push_pkt(32'h00210202, 4'd1);
    @(negedge clk);
    r0 = rr_cyc.size();
    @(posedge clk); #1;
    req_valid = 1'b1; req_dst_x = 8'h01; req_dst_y = 8'h01; req_len = 4'd1;
    @(negedge clk);
    @(posedge clk); #1;
    req_dst_x = 8'h02; req_dst_y = 8'h02; req_len = 4'd1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) timeout_fail("b2b_second_accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain("b2b");
    if (flit_cyc.size() >= n0 + 4 && rr_cyc.size() >= r0 + 1) begin
      chk("b2b_gap_body1", 64'(flit_cyc[n0 + 1] - flit_cyc[n0]), 64'd1);
      chk("b2b_gap_head2", 64'(flit_cyc[n0 + 2] - flit_cyc[n0]), 64'd3);
      chk("b2b_gap_body2", 64'(flit_cyc[n0 + 3] - flit_cyc[n0]), 64'd4);
      chk("b2b_req_ready_rise", 64'(rr_cyc[r0]), 64'(flit_cyc[n0 + 1]));
    end else begin
      timeout_fail("b2b_flit_count");
    end

    // Table of packets, random payload gaps and credit return timing
    do_reset();
    auto_credit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pl_gaps = vecs[i].gaps;
      base = flit_cnt;
      push_pkt(vecs[i].exp_hdr, vecs[i].len);
      issue_req(vecs[i].x, vecs[i].y, vecs[i].len);
      wait_drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_flits", i), 64'(flit_cnt - base), 64'(int'(vecs[i].len) + 1));
      chk($sformatf("vec%0d_credits", i), 64'(dbg_credits), 64'd4);
      chk($sformatf("vec%0d_err", i), 64'(credit_err), 64'd0);
    end
    pl_gaps = 1'b0;

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
